// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/seq_divider_operand_magnitude.sv
// Conditional two's-complement negate: y = en ? -a : a. Purely combinational.
module operand_magnitude #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock: 34 cycles start-to-done, 2 on divide-by-zero.
// No queueing: start is only taken while busy is low; results hold until the next done.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [5:0] CNT_LOAD = 6'(DIV_ITER - 1);

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fixed, r_fixed;
  logic [WIDTH:0]   shifted, diff;
  logic             prem_msb_unused;

  operand_magnitude #(.WIDTH(WIDTH)) u_mag_dividend (
    .en (signed_op & dividend[WIDTH-1]),
    .a  (dividend),
    .y  (dvd_mag)
  );

  operand_magnitude #(.WIDTH(WIDTH)) u_mag_divisor (
    .en (signed_op & divisor[WIDTH-1]),
    .a  (divisor),
    .y  (dvs_mag)
  );

  operand_magnitude #(.WIDTH(WIDTH)) u_fix_quotient (
    .en (neg_q_q),
    .a  (dq_q),
    .y  (q_fixed)
  );

  operand_magnitude #(.WIDTH(WIDTH)) u_fix_remainder (
    .en (neg_r_q),
    .a  (prem_q[WIDTH-1:0]),
    .y  (r_fixed)
  );

  // Partial remainder never exceeds the divisor, so its top bit stays clear between steps.
  assign prem_msb_unused = prem_q[WIDTH];
  assign shifted = {prem_q[WIDTH-1:0], dq_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_q_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = signed_op & dividend[WIDTH-1];
          dvs_d   = dvs_mag;
          prem_d  = '0;
          cnt_d   = CNT_LOAD;
          zero_d  = (divisor == '0);
          // On divide-by-zero the raw dividend is kept so it can be returned unchanged.
          dq_d    = (divisor == '0) ? dividend : dvd_mag;
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        prem_d = diff[WIDTH] ? shifted : diff;
        dq_d   = {dq_q[WIDTH-2:0], ~diff[WIDTH]};
        if (cnt_q == 6'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        dbz_d   = zero_q;
        quot_d  = zero_q ? WIDTH'(DBZ_QUOTIENT) : q_fixed;
        rem_d   = zero_q ? dq_q : r_fixed;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with hand-computed quotients, remainders and latencies.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time just after the edge that sampled start (edge 0).
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Edges after edge 0 until done is seen (-1 on timeout); busy cycles counted from edge 0.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) begin
        edges = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_unsigned();
    int e, b;
    issue(1'b0, 32'd100, 32'd7);
    wait_done(e, b);
    total++; if (e !== 33) begin bad++; $display("FAIL unsigned_latency: got %0d want 33 edges", e); end
    total++; if (b !== 33) begin bad++; $display("FAIL unsigned_busy_cycles: got %0d want 33", b); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL unsigned_q: got %h want %h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL unsigned_r: got %h want %h", remainder, 32'd2); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL unsigned_dbz: got %b want 0", div_by_zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_cycle_busy: got %b want 0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL unsigned_q_hold: got %h want %h", quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int e, b;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(e, b);
    total++; if (e !== 33) begin bad++; $display("FAIL signed_neg_latency: got %0d want 33 edges", e); end
    total++; if (quotient !== 32'hFFFF_FFF2) begin bad++; $display("FAIL signed_neg_dvd_q: got %h want fffffff2", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFE) begin bad++; $display("FAIL signed_neg_dvd_r: got %h want fffffffe", remainder); end
    issue(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(e, b);
    total++; if (quotient !== 32'hFFFF_FFF2) begin bad++; $display("FAIL signed_neg_dvs_q: got %h want fffffff2", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL signed_neg_dvs_r: got %h want 00000002", remainder); end
  endtask

  task automatic test_div_by_zero();
    int e, b;
    for (int m = 0; m < 2; m++) begin
      issue(m[0], 32'h1234_5678, 32'h0);
      wait_done(e, b);
      total++; if (e !== 1) begin bad++; $display("FAIL dbz_latency mode=%0d: got %0d want 1 edge", m, e); end
      total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_q mode=%0d: got %h want ffffffff", m, quotient); end
      total++; if (remainder !== 32'h1234_5678) begin bad++; $display("FAIL dbz_r mode=%0d: got %h want 12345678", m, remainder); end
      total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag mode=%0d: got %b want 1", m, div_by_zero); end
    end
    issue(1'b0, 32'd100, 32'd7);
    wait_done(e, b);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL dbz_next_q: got %h want %h", quotient, 32'd14); end
  endtask

  task automatic test_overflow();
    int e, b;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, b);
    total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL ovf_signed_q: got %h want 80000000", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL ovf_signed_r: got %h want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_signed_dbz: got %b want 0", div_by_zero); end
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, b);
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL ovf_unsigned_q: got %h want 0", quotient); end
    total++; if (remainder !== 32'h8000_0000) begin bad++; $display("FAIL ovf_unsigned_r: got %h want 80000000", remainder); end
  endtask

  task automatic test_start_ignored();
    int e;
    issue(1'b0, 32'd100, 32'd7);
    e = -1;
    for (int k = 1; k <= 100; k++) begin
      start = (k == 10);
      if (k == 10) begin
        signed_op = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end
      tick();
      if (done) begin
        e = k;
        break;
      end
    end
    start = 1'b0;
    total++; if (e !== 33) begin bad++; $display("FAIL restart_latency: got %0d want 33 edges", e); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL restart_q: got %h want %h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL restart_r: got %h want %h", remainder, 32'd2); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_no_queue: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int e, b;
    issue(1'b0, 32'd1000, 32'd10);
    wait_done(e, b);
    total++; if (quotient !== 32'd100) begin bad++; $display("FAIL b2b_first_q: got %h want %h", quotient, 32'd100); end
    issue(1'b0, 32'd77, 32'd8);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    wait_done(e, b);
    total++; if (e !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33 edges", e); end
    total++; if (quotient !== 32'd9) begin bad++; $display("FAIL b2b_second_q: got %h want %h", quotient, 32'd9); end
    total++; if (remainder !== 32'd5) begin bad++; $display("FAIL b2b_second_r: got %h want %h", remainder, 32'd5); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL midrst_q: got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL midrst_r: got %h want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_dbz: got %b want 0", div_by_zero); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring integer divider for the KGP_RISC execute stage, the inverse companion to the ALU's single-cycle array multiplier. It accepts a 32-bit dividend/divisor pair with a start pulse, iterates one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse. It supports signed and unsigned operation and stalls the pipeline via `busy` while computing.

## Interface
- `WIDTH`, 32, operand/result width; all widths below are `WIDTH`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; accepted only while `busy`=0.
- `signed_op`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with `start`.
- `dividend`  in  32  sampled with `start`.
- `divisor`  in  32  sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  registered one-cycle pulse; results valid in the same cycle.
- `quotient`  out  32  held from `done` until the next `done`.
- `remainder`  out  32  held from `done` until the next `done`.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with results.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE: on `start`, latch operands. If `signed_op`, latch magnitudes (negate if bit 31 set) and record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend); else both flags are 0. Load the 6-bit counter with 31 and clear the partial remainder.
  - Divisor == 0 goes to FIX with the zero flag set.
  - Otherwise go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - At counter 0 go to FIX; otherwise decrement.
- FIX: apply signs:
  - `quotient` = `neg_q` ? -q : q.
  - `remainder` = `neg_r` ? -r : r.
  - The remainder carries the dividend's sign (truncating division).
  - Pulse `done` and return to IDLE.
- Divide by zero: `quotient`=0xFFFFFFFF and `remainder`=original dividend, unsigned or signed. `div_by_zero`=1; otherwise 0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `quotient`=0x80000000 (negation wraps) and `remainder`=0. No flag.
- `start` while `busy` is ignored: no queueing, and latched operands are unaffected.
- `start` in the same cycle as `done` is accepted, because state is IDLE then.
- Operand inputs may change freely after acceptance.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0.
- `rst` mid-operation aborts immediately. The next cycle shows reset values and no `done`.
- Normal latency: `start` sampled at edge 0. CALC occupies edges 1–32 and FIX executes at edge 33. `done`=1 and results are valid in the cycle following edge 33, so 34 cycles start-to-done. `busy` is high for cycles following edges 0–32.
- Divide-by-zero latency: `start` at edge 0, FIX at edge 1, `done` in the cycle following edge 1.
- Maximum throughput is one division per 34 cycles.

## Structure
- Shared package `divider_pkg`:
  - state enum (IDLE=2'b00, CALC=2'b01, FIX=2'b10);
  - `DIV_WIDTH`=32;
  - `DIV_ITER`=32;
  - `DBZ_QUOTIENT`=32'hFFFFFFFF.
- One sub-module, `operand_magnitude`: combinational conditional two's-complement negate (`en`, `a` -> `y`). It is instantiated for dividend and divisor magnitude, and reused for the quotient and remainder sign fix.
- Datapath registers:
  - 33-bit partial remainder;
  - 32-bit dividend/quotient shift register;
  - 32-bit divisor magnitude;
  - sign flags;
  - counter.

## Test plan
- Unsigned 100 / 7 -> `quotient`=14, `remainder`=2, `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- Signed -100 (0xFFFFFF9C) / 7 -> `quotient`=0xFFFFFFF2, `remainder`=0xFFFFFFFE. Signed 100 / -7 -> `quotient`=0xFFFFFFF2, `remainder`=2.
- Divisor 0, dividend 0x12345678, either mode -> `done` 2 cycles after `start`, `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1. The next normal divide clears `div_by_zero`.
- 0x80000000 / 0xFFFFFFFF:
  - signed -> `quotient`=0x80000000, `remainder`=0;
  - unsigned -> `quotient`=0, `remainder`=0x80000000.
- `start` re-pulsed at cycle 10 with different operands -> ignored; original results appear at cycle 34. `start` asserted in the `done` cycle -> accepted, and the second `done` arrives 34 cycles later.
- `rst` at cycle 15 of a divide -> all outputs return to 0 the next cycle; no `done` pulse follows.
